// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and fault-code type for the fetch PC stage
package fetch_pkg;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {FC_NONE, FC_RANGE, FC_UNDERFLOW, FC_NORET} fault_code_e;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: redirect controls, instruction word and PC/status outputs of the fetch stage
interface fetch_pc_unit_if;
  logic stall, branch_taken, jump, call, ret, halted, fault;
  logic [31:0] branch_target, jump_target, instruction, PC, pc_plus4;
  logic [1:0] fault_code;
  modport master(output stall, branch_taken, branch_target, jump, jump_target, call, ret, instruction,
                 input PC, pc_plus4, halted, fault, fault_code);
  modport slave(input stall, branch_taken, branch_target, jump, jump_target, call, ret, instruction,
                output PC, pc_plus4, halted, fault, fault_code);
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular LIFO of return addresses; push on full overwrites the oldest (ports: push, pop, d, top, empty, full)
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] d,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW:0] cnt;
  assign top = mem[wp - PW'(1)];
  assign empty = cnt == '0;
  assign full = cnt == (PW+1)'(DEPTH);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      cnt <= '0;
    end else if (pop) begin
      wp <= wp - PW'(1);
      cnt <= cnt - 1'b1;
    end else if (push) begin
      wp <= wp + PW'(1);
      cnt <= full ? cnt : cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !pop) mem[wp] <= d;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and next-PC select with halt/fault traps; FETCH_RAS_EN builds the return-address stack
// ports: clk, reset (async, active-high), bus (slave: redirect inputs, instruction in; PC, pc_plus4, halted, fault, fault_code out)
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int IMEM_BYTES = 256,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  fetch_pc_unit_if.slave bus
);
  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);
  logic [31:0] pc_q, target, ras_top;
  logic halted_q, fault_q, live, go, ret_err, bad, load, ras_empty;
  fault_code_e code_q, ret_code;
  assign bus.PC = pc_q;
  assign bus.pc_plus4 = pc_q + 32'd4;
  assign bus.halted = halted_q;
  assign bus.fault = fault_q;
  assign bus.fault_code = code_q;
  assign live = !(halted_q || fault_q || bus.stall);
  assign go = live && bus.instruction != HALT_INSTR;
  always_comb target = bus.ret ? ras_top : (bus.call || bus.jump) ? bus.jump_target :
                       bus.branch_taken ? bus.branch_target : bus.pc_plus4;
  assign ret_err = bus.ret && ras_empty;
  // one range check covers redirect targets and sequential wrap/overflow alike
  assign bad = |target[1:0] || target > PC_MAX;
  assign load = go && !ret_err && !bad;
`ifdef FETCH_RAS_EN
  logic unused_full;
  return_addr_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk, .reset,
    .push(load && bus.call && !bus.ret),
    .pop(go && bus.ret && !ras_empty),
    .d(bus.pc_plus4), .top(ras_top), .empty(ras_empty), .full(unused_full)
  );
  assign ret_code = FC_UNDERFLOW;
`else
  // without a stack every ret is treated as an empty-stack return with its own code
  assign ras_top = '0;
  assign ras_empty = 1'b1;
  assign ret_code = FC_NORET;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q <= RESET_PC;
      halted_q <= 1'b0;
      fault_q <= 1'b0;
      code_q <= FC_NONE;
    end else begin
      if (load) pc_q <= target;
      if (live && bus.instruction == HALT_INSTR) halted_q <= 1'b1;
      if (go && (ret_err || bad)) begin
        fault_q <= 1'b1;
        code_q <= ret_err ? ret_code : FC_RANGE;
      end
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter stage of the single-cycle processor: holds the architectural PC, drives it straight into the byte-addressed instruction memory, and selects the next PC each cycle from sequential, branch, jump, call and return sources. It detects the halt instruction, traps illegal or out-of-range redirect targets, and optionally keeps a small return-address stack so `ret` needs no register-file read.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- IMEM_BYTES, 256, instruction memory size in bytes; legal PC range is 0 .. IMEM_BYTES-4
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC and all state this cycle
- branch_taken  in  1  conditional branch resolved taken
- branch_target  in  32  branch destination
- jump  in  1  unconditional jump
- jump_target  in  32  jump/call destination
- call  in  1  jump to jump_target and push pc_plus4
- ret  in  1  return to popped address
- instruction  in  32  current instruction from memory (halt detection only)
- PC  out  32  current program counter
- pc_plus4  out  32  PC + 4, combinational
- halted  out  1  sticky halt flag
- fault  out  1  sticky trap flag
- fault_code  out  2  0 none, 1 misaligned/out-of-range target, 2 RAS underflow, 3 ret unsupported

## Operation
- Reset (any time, async): PC=RESET_PC, halted=0, fault=0, fault_code=0, RAS empty. Takes effect immediately, mid-redirect or mid-stall.
- Next-PC priority at each edge: halted or fault (hold) > stall (hold) > ret > call > jump > branch_taken > pc_plus4.
- Simultaneous call and ret: ret wins, no push.
- Target check on the selected redirect target: low two bits nonzero or target > IMEM_BYTES-4 -> fault=1, fault_code=1, PC unchanged.
- Sequential wrap: pc_plus4 > IMEM_BYTES-4 -> fault=1, fault_code=1, PC unchanged.
- Halt: instruction == 32'hFFFF_FFFF and not stalled -> halted=1 at the edge, PC unchanged; redirect inputs that cycle ignored.
- halted and fault are sticky until reset; PC frozen while either is set.
- pc_plus4 is 32-bit modulo arithmetic; the range check above catches overflow.
- RAS: call pushes pc_plus4 of the call instruction. Push when full overwrites the oldest entry (circular), no fault. ret pops top entry into PC (target check still applied). ret when empty -> fault=1, fault_code=2.
- Stall blocks push and pop.

## Timing
- PC is registered; changes only on rising clk or reset.
- Memory read is combinational, so instruction corresponds to current PC in the same cycle.
- Redirect inputs sampled at the edge; new PC visible immediately after it; zero-bubble redirect.
- halted, fault, fault_code update at the same edge as the event; the faulting cycle's PC remains on the PC output.

## Configuration
- FETCH_RAS_EN defined: return-address stack built as above.
- Not defined: no stack storage; call behaves exactly as jump (no push); ret -> fault=1, fault_code=3, PC unchanged.

## Structure
- Package fetch_pkg: HALT_INSTR constant (32'hFFFF_FFFF), fault-code typedef/enum with the four values, default RESET_PC.
- One sub-module: return_addr_stack (push, pop, top, empty, full; circular overwrite on full), instantiated only under FETCH_RAS_EN.

## Test plan
- Reset with RESET_PC=0, run 3 cycles -> PC 0, 4, 8, 12; assert reset mid-run -> PC=0 immediately, before the next edge.
- PC=8, branch_taken=1, target=0x40 with jump=1, jump_target=0x80 in the same cycle -> PC=0x80; next cycle stall=1 -> PC stays 0x80.
- jump_target=0x42 -> fault=1, fault_code=1, PC holds; further edges keep PC; reset clears the flags.
- FETCH_RAS_EN: call at PC=0x10 to 0x40, then ret at 0x48 -> PC=0x14; 5 calls with RAS_DEPTH=4, then 4 rets -> last 4 return addresses in LIFO order; a 5th ret -> fault_code=2.
- Without FETCH_RAS_EN: ret at PC=0x20 -> fault=1, fault_code=3, PC=0x20.
- instruction=32'hFFFF_FFFF at PC=0x0C with jump=1 -> halted=1, PC stays 0x0C indefinitely; with stall=1 that cycle, no halt until stall drops.
